// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - RV32I opcode, funct and ALU-operation definitions
package rv32i_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Only bit 30 of funct7 distinguishes SUB/SRA from ADD/SRL.
  localparam logic [6:0] F7_ALT = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

endpackage

// File: rtl/rv32i_alu.sv
// rtl/rv32i_alu.sv - combinational RV32I integer ALU
module rv32i_alu
  import rv32i_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     alu_op,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'b0, a < b};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_id_ex_mem.sv
// rtl/rv32i_id_ex_mem.sv - RV32I decode/execute/memory datapath with private DMEM
// Optional RV32_MEM_SUBWORD_EN enables byte/halfword loads and stores.
module rv32i_id_ex_mem
  import rv32i_pkg::*;
#(
  parameter int DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IF_ID_IR,
  input  logic [31:0] IF_ID_NPC,
  input  logic [31:0] PC,
  output logic [4:0]  RS1_ADDR,
  output logic [4:0]  RS2_ADDR,
  input  logic [31:0] RS1_DATA,
  input  logic [31:0] RS2_DATA,
  output logic        BR_TAKEN,
  output logic [31:0] BR_TARGET,
  output logic [31:0] MEM_WB_PC,
  output logic [31:0] MEM_WB_IR,
  output logic [31:0] MEM_WB_ALU_OUT,
  output logic [31:0] MEM_WB_LMD,
  output logic [4:0]  MEM_WB_RD,
  output logic        MEM_WB_RD_WE
);

  localparam int AW = $clog2(DMEM_WORDS);

  logic [31:0] id_ex_ir_q, id_ex_pc_q, id_ex_npc_q, id_ex_a_q, id_ex_b_q, id_ex_imm_q;
  logic [31:0] id_ex_a_d, id_ex_b_d, id_ex_imm_d;
  logic [31:0] ex_mem_ir_q, ex_mem_pc_q, ex_mem_b_q, ex_mem_alu_out_q, ex_mem_target_q;
  logic [31:0] ex_mem_alu_out_d, ex_mem_target_d;
  logic [4:0]  ex_mem_rd_q, ex_mem_rd_d;
  logic        ex_mem_rd_we_q, ex_mem_rd_we_d, ex_mem_taken_q, ex_mem_taken_d;
  logic [31:0] mem_wb_ir_q, mem_wb_pc_q, mem_wb_alu_out_q, mem_wb_lmd_q, mem_wb_lmd_d;
  logic [4:0]  mem_wb_rd_q;
  logic        mem_wb_rd_we_q;
  logic [31:0] dmem_q [DMEM_WORDS];
  logic [31:0] dmem_wdata_d;

  assign RS1_ADDR = IF_ID_IR[19:15];
  assign RS2_ADDR = IF_ID_IR[24:20];

  // ---------------- ID ----------------
  always_comb begin
    id_ex_a_d   = (IF_ID_IR[19:15] == 5'd0) ? 32'd0 : RS1_DATA;
    id_ex_b_d   = (IF_ID_IR[24:20] == 5'd0) ? 32'd0 : RS2_DATA;
    id_ex_imm_d = '0;
    case (IF_ID_IR[6:0])
      OP_IMM, LOAD, JALR: id_ex_imm_d = {{20{IF_ID_IR[31]}}, IF_ID_IR[31:20]};
      STORE:  id_ex_imm_d = {{20{IF_ID_IR[31]}}, IF_ID_IR[31:25], IF_ID_IR[11:7]};
      BRANCH: id_ex_imm_d = {{19{IF_ID_IR[31]}}, IF_ID_IR[31], IF_ID_IR[7],
                             IF_ID_IR[30:25], IF_ID_IR[11:8], 1'b0};
      LUI, AUIPC: id_ex_imm_d = {IF_ID_IR[31:12], 12'b0};
      JAL:    id_ex_imm_d = {{11{IF_ID_IR[31]}}, IF_ID_IR[31], IF_ID_IR[19:12],
                             IF_ID_IR[20], IF_ID_IR[30:21], 1'b0};
      default: id_ex_imm_d = '0;
    endcase
  end

  // ---------------- EX ----------------
  logic [6:0]  ex_opc;
  logic [2:0]  ex_f3;
  logic        ex_alt;
  logic [31:0] alu_b, alu_res, pc_plus_imm;
  logic        br_cond, ex_writes;
  alu_op_t     alu_op;

  assign ex_opc      = id_ex_ir_q[6:0];
  assign ex_f3       = id_ex_ir_q[14:12];
  assign ex_alt      = id_ex_ir_q[30] == F7_ALT[5];
  assign alu_b       = (ex_opc == OP) ? id_ex_b_q : id_ex_imm_q;
  assign pc_plus_imm = id_ex_pc_q + id_ex_imm_q;

  always_comb begin
    alu_op = ALU_ADD;
    if (ex_opc == OP || ex_opc == OP_IMM) begin
      case (ex_f3)
        F3_ADD:  alu_op = (ex_opc == OP && ex_alt) ? ALU_SUB : ALU_ADD;
        F3_SLL:  alu_op = ALU_SLL;
        F3_SLT:  alu_op = ALU_SLT;
        F3_SLTU: alu_op = ALU_SLTU;
        F3_XOR:  alu_op = ALU_XOR;
        F3_SR:   alu_op = ex_alt ? ALU_SRA : ALU_SRL;
        F3_OR:   alu_op = ALU_OR;
        F3_AND:  alu_op = ALU_AND;
        default: alu_op = ALU_ADD;
      endcase
    end
  end

  rv32i_alu u_alu (
    .a      (id_ex_a_q),
    .b      (alu_b),
    .alu_op (alu_op),
    .result (alu_res)
  );

  always_comb begin
    case (ex_f3)
      F3_BEQ:  br_cond = id_ex_a_q == id_ex_b_q;
      F3_BNE:  br_cond = id_ex_a_q != id_ex_b_q;
      F3_BLT:  br_cond = $signed(id_ex_a_q) < $signed(id_ex_b_q);
      F3_BGE:  br_cond = $signed(id_ex_a_q) >= $signed(id_ex_b_q);
      F3_BLTU: br_cond = id_ex_a_q < id_ex_b_q;
      F3_BGEU: br_cond = id_ex_a_q >= id_ex_b_q;
      default: br_cond = 1'b0;
    endcase
  end

  always_comb begin
    ex_mem_alu_out_d = '0;
    ex_mem_taken_d   = 1'b0;
    ex_mem_target_d  = '0;
    ex_writes        = 1'b0;
    case (ex_opc)
      OP, OP_IMM, LOAD: begin
        ex_mem_alu_out_d = alu_res;
        ex_writes        = 1'b1;
      end
      STORE: ex_mem_alu_out_d = alu_res;
      LUI: begin
        ex_mem_alu_out_d = id_ex_imm_q;
        ex_writes        = 1'b1;
      end
      AUIPC: begin
        ex_mem_alu_out_d = pc_plus_imm;
        ex_writes        = 1'b1;
      end
      JAL: begin
        ex_mem_alu_out_d = id_ex_npc_q;
        ex_mem_taken_d   = 1'b1;
        ex_mem_target_d  = pc_plus_imm;
        ex_writes        = 1'b1;
      end
      JALR: begin
        ex_mem_alu_out_d = id_ex_npc_q;
        ex_mem_taken_d   = 1'b1;
        ex_mem_target_d  = {alu_res[31:1], 1'b0};
        ex_writes        = 1'b1;
      end
      BRANCH: begin
        ex_mem_taken_d  = br_cond;
        ex_mem_target_d = pc_plus_imm;
      end
      default: ;
    endcase
    ex_mem_rd_we_d = ex_writes && (id_ex_ir_q[11:7] != 5'd0);
    ex_mem_rd_d    = ex_mem_rd_we_d ? id_ex_ir_q[11:7] : 5'd0;
  end

  // ---------------- MEM ----------------
  logic [AW-1:0] mem_idx;
  logic [31:0]   mem_word, load_val;
  logic          store_en;

  assign mem_idx  = ex_mem_alu_out_q[AW+1:2];
  assign mem_word = dmem_q[mem_idx];
  assign store_en = ex_mem_ir_q[6:0] == STORE;

`ifdef RV32_MEM_SUBWORD_EN
  logic [1:0]  mem_off;
  logic [2:0]  mem_f3;
  logic [3:0]  mem_be;
  logic [31:0] st_lanes, ld_lane;

  assign mem_off = ex_mem_alu_out_q[1:0];
  assign mem_f3  = ex_mem_ir_q[14:12];
  assign ld_lane = mem_word >> {mem_off, 3'b000};

  always_comb begin
    case (mem_f3[1:0])
      2'b00: begin
        mem_be   = 4'b0001 << mem_off;
        st_lanes = {4{ex_mem_b_q[7:0]}};
      end
      2'b01: begin
        mem_be   = 4'b0011 << {mem_off[1], 1'b0};
        st_lanes = {2{ex_mem_b_q[15:0]}};
      end
      default: begin
        mem_be   = 4'b1111;
        st_lanes = ex_mem_b_q;
      end
    endcase
    for (int i = 0; i < 4; i++)
      dmem_wdata_d[8*i +: 8] = mem_be[i] ? st_lanes[8*i +: 8] : mem_word[8*i +: 8];
    case (mem_f3)
      F3_LB:   load_val = {{24{ld_lane[7]}}, ld_lane[7:0]};
      F3_LH:   load_val = {{16{ld_lane[15]}}, ld_lane[15:0]};
      F3_LBU:  load_val = {24'b0, ld_lane[7:0]};
      F3_LHU:  load_val = {16'b0, ld_lane[15:0]};
      default: load_val = mem_word;
    endcase
  end
`else
  assign dmem_wdata_d = ex_mem_b_q;
  assign load_val     = mem_word;
`endif

  assign mem_wb_lmd_d = (ex_mem_ir_q[6:0] == LOAD) ? load_val : 32'd0;

  // Memory is not reset; a store is suppressed on any reset edge.
  always_ff @(posedge clk) begin
    if (!rst && store_en)
      dmem_q[mem_idx] <= dmem_wdata_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_ir_q       <= '0;
      id_ex_pc_q       <= '0;
      id_ex_npc_q      <= '0;
      id_ex_a_q        <= '0;
      id_ex_b_q        <= '0;
      id_ex_imm_q      <= '0;
      ex_mem_ir_q      <= '0;
      ex_mem_pc_q      <= '0;
      ex_mem_b_q       <= '0;
      ex_mem_alu_out_q <= '0;
      ex_mem_rd_q      <= '0;
      ex_mem_rd_we_q   <= 1'b0;
      ex_mem_taken_q   <= 1'b0;
      ex_mem_target_q  <= '0;
      mem_wb_ir_q      <= '0;
      mem_wb_pc_q      <= '0;
      mem_wb_alu_out_q <= '0;
      mem_wb_lmd_q     <= '0;
      mem_wb_rd_q      <= '0;
      mem_wb_rd_we_q   <= 1'b0;
    end else begin
      id_ex_ir_q       <= IF_ID_IR;
      id_ex_pc_q       <= PC;
      id_ex_npc_q      <= IF_ID_NPC;
      id_ex_a_q        <= id_ex_a_d;
      id_ex_b_q        <= id_ex_b_d;
      id_ex_imm_q      <= id_ex_imm_d;
      ex_mem_ir_q      <= id_ex_ir_q;
      ex_mem_pc_q      <= id_ex_pc_q;
      ex_mem_b_q       <= id_ex_b_q;
      ex_mem_alu_out_q <= ex_mem_alu_out_d;
      ex_mem_rd_q      <= ex_mem_rd_d;
      ex_mem_rd_we_q   <= ex_mem_rd_we_d;
      ex_mem_taken_q   <= ex_mem_taken_d;
      ex_mem_target_q  <= ex_mem_target_d;
      mem_wb_ir_q      <= ex_mem_ir_q;
      mem_wb_pc_q      <= ex_mem_pc_q;
      mem_wb_alu_out_q <= ex_mem_alu_out_q;
      mem_wb_lmd_q     <= mem_wb_lmd_d;
      mem_wb_rd_q      <= ex_mem_rd_q;
      mem_wb_rd_we_q   <= ex_mem_rd_we_q;
    end
  end

  assign BR_TAKEN       = ex_mem_taken_q;
  assign BR_TARGET      = ex_mem_target_q;
  assign MEM_WB_PC      = mem_wb_pc_q;
  assign MEM_WB_IR      = mem_wb_ir_q;
  assign MEM_WB_ALU_OUT = mem_wb_alu_out_q;
  assign MEM_WB_LMD     = mem_wb_lmd_q;
  assign MEM_WB_RD      = mem_wb_rd_q;
  assign MEM_WB_RD_WE   = mem_wb_rd_we_q;

endmodule

// File: tb/tb_rv32i_id_ex_mem.sv
// tb/tb_rv32i_id_ex_mem.sv - directed vector bench for rv32i_id_ex_mem (RV32_MEM_SUBWORD_EN aware)
module tb_rv32i_id_ex_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IF_ID_IR, IF_ID_NPC, PC, RS1_DATA, RS2_DATA;
  logic [4:0]  RS1_ADDR, RS2_ADDR;
  logic        BR_TAKEN;
  logic [31:0] BR_TARGET, MEM_WB_PC, MEM_WB_IR, MEM_WB_ALU_OUT, MEM_WB_LMD;
  logic [4:0]  MEM_WB_RD;
  logic        MEM_WB_RD_WE;

  int tests = 0;
  int fails = 0;

  rv32i_id_ex_mem dut (
    .clk            (clk),
    .rst            (rst),
    .IF_ID_IR       (IF_ID_IR),
    .IF_ID_NPC      (IF_ID_NPC),
    .PC             (PC),
    .RS1_ADDR       (RS1_ADDR),
    .RS2_ADDR       (RS2_ADDR),
    .RS1_DATA       (RS1_DATA),
    .RS2_DATA       (RS2_DATA),
    .BR_TAKEN       (BR_TAKEN),
    .BR_TARGET      (BR_TARGET),
    .MEM_WB_PC      (MEM_WB_PC),
    .MEM_WB_IR      (MEM_WB_IR),
    .MEM_WB_ALU_OUT (MEM_WB_ALU_OUT),
    .MEM_WB_LMD     (MEM_WB_LMD),
    .MEM_WB_RD      (MEM_WB_RD),
    .MEM_WB_RD_WE   (MEM_WB_RD_WE)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] ir, pc, rs1, rs2;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        we, taken;
    logic [31:0] target;
    logic        chk_alu, chk_tgt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic [31:0] ir, pc, rs1, rs2, alu,
                     input logic [4:0] rd, input logic we, taken,
                     input logic [31:0] target, input logic chk_alu, chk_tgt);
    vec_t v;
    v.name = n; v.ir = ir; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.alu = alu;
    v.rd = rd; v.we = we; v.taken = taken; v.target = target;
    v.chk_alu = chk_alu; v.chk_tgt = chk_tgt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ir, pc, rs1, rs2);
    IF_ID_IR = ir; PC = pc; IF_ID_NPC = pc + 32'd4; RS1_DATA = rs1; RS2_DATA = rs2;
  endtask

  task automatic bubble();
    issue(32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bubble();
    tick();
    chk("rst.taken",  {31'd0, BR_TAKEN}, 32'd0);
    chk("rst.target", BR_TARGET, 32'd0);
    chk("rst.ir",     MEM_WB_IR, 32'd0);
    chk("rst.pc",     MEM_WB_PC, 32'd0);
    chk("rst.alu",    MEM_WB_ALU_OUT, 32'd0);
    chk("rst.lmd",    MEM_WB_LMD, 32'd0);
    chk("rst.rd",     {27'd0, MEM_WB_RD}, 32'd0);
    chk("rst.we",     {31'd0, MEM_WB_RD_WE}, 32'd0);
    rst = 1'b0;

    //  name      ir            pc         rs1           rs2           alu           rd we tk target      ca ct
    add("addi",   32'h00500093, 32'h000, 32'h00000123, 32'h0,        32'd5,        1, 1, 0, 32'h0,      1, 0);
    add("sub",    32'h402081B3, 32'h004, 32'd3,        32'd5,        32'hFFFFFFFE, 3, 1, 0, 32'h0,      1, 0);
    add("sra",    32'h4020D233, 32'h008, 32'h80000000, 32'd4,        32'hF8000000, 4, 1, 0, 32'h0,      1, 0);
    add("sltu",   32'h0020B2B3, 32'h00C, 32'd1,        32'hFFFFFFFF, 32'd1,        5, 1, 0, 32'h0,      1, 0);
    add("sll",    32'h002094B3, 32'h010, 32'd1,        32'h24,       32'h10,       9, 1, 0, 32'h0,      1, 0);
    add("srai",   32'h4040D513, 32'h014, 32'h80000000, 32'h0,        32'hF8000000, 10, 1, 0, 32'h0,     1, 0);
    add("addi_n", 32'hC0008593, 32'h018, 32'h1000,     32'h0,        32'hC00,      11, 1, 0, 32'h0,     1, 0);
    add("addi_x0",32'h00100013, 32'h01C, 32'h0,        32'h0,        32'd1,        0, 0, 0, 32'h0,      1, 0);
    add("lui",    32'h12345337, 32'h030, 32'h0,        32'h0,        32'h12345000, 6, 1, 0, 32'h0,      1, 0);
    add("auipc",  32'h00001397, 32'h040, 32'h0,        32'h0,        32'h1040,     7, 1, 0, 32'h0,      1, 0);
    add("jal",    32'h008000EF, 32'h020, 32'h0,        32'h0,        32'h24,       1, 1, 1, 32'h28,     1, 1);
    add("jalr",   32'h00308467, 32'h050, 32'h1000,     32'h0,        32'h54,       8, 1, 1, 32'h1002,   1, 1);
    add("beq_t",  32'h00208863, 32'h100, 32'd7,        32'd7,        32'h0,        0, 0, 1, 32'h110,    0, 1);
    add("beq_nt", 32'h00208863, 32'h100, 32'd7,        32'd8,        32'h0,        0, 0, 0, 32'h110,    0, 1);
    add("blt_t",  32'h0020C463, 32'h200, 32'hFFFFFFFF, 32'd1,        32'h0,        0, 0, 1, 32'h208,    0, 1);
    add("bltu_nt",32'h0020E463, 32'h200, 32'hFFFFFFFF, 32'd1,        32'h0,        0, 0, 0, 32'h208,    0, 1);
    add("unknown",32'hFFFFFFFF, 32'h300, 32'h55,       32'h66,       32'h0,        0, 0, 0, 32'h0,      1, 0);

    issue(32'h402081B3, 32'h0, 32'h0, 32'h0);
    #1;
    chk("rs1_addr", {27'd0, RS1_ADDR}, 32'd1);
    chk("rs2_addr", {27'd0, RS2_ADDR}, 32'd2);

    foreach (vecs[k]) begin
      issue(vecs[k].ir, vecs[k].pc, vecs[k].rs1, vecs[k].rs2);
      tick();
      bubble();
      tick();
      chk({vecs[k].name, ".taken"}, {31'd0, BR_TAKEN}, {31'd0, vecs[k].taken});
      if (vecs[k].chk_tgt) chk({vecs[k].name, ".target"}, BR_TARGET, vecs[k].target);
      tick();
      if (vecs[k].chk_alu) chk({vecs[k].name, ".alu"}, MEM_WB_ALU_OUT, vecs[k].alu);
      chk({vecs[k].name, ".we"}, {31'd0, MEM_WB_RD_WE}, {31'd0, vecs[k].we});
      if (vecs[k].we) chk({vecs[k].name, ".rd"}, {27'd0, MEM_WB_RD}, {27'd0, vecs[k].rd});
      chk({vecs[k].name, ".ir"}, MEM_WB_IR, vecs[k].ir);
      chk({vecs[k].name, ".pc"}, MEM_WB_PC, vecs[k].pc);
    end

    // SW x2,8(x0) immediately followed by LW x3,8(x0)
    issue(32'h00202423, 32'h400, 32'h55, 32'hDEADBEEF);
    tick();
    issue(32'h00802183, 32'h404, 32'h55, 32'h0);
    tick();
    bubble();
    tick();
    tick();
    chk("sw_lw.lmd", MEM_WB_LMD, 32'hDEADBEEF);
    chk("sw_lw.rd",  {27'd0, MEM_WB_RD}, 32'd3);
    chk("sw_lw.we",  {31'd0, MEM_WB_RD_WE}, 32'd1);
    chk("sw_lw.alu", MEM_WB_ALU_OUT, 32'd8);

    // LW x3,1032(x0) wraps onto word 2
    issue(32'h40802183, 32'h408, 32'h0, 32'h0);
    tick(); bubble(); tick(); tick();
    chk("wrap.lmd", MEM_WB_LMD, 32'hDEADBEEF);

    // SW x2,12(x0) = 0x22222222, then a second SW hit by reset on its MEM edge
    issue(32'h00202623, 32'h410, 32'h0, 32'h22222222);
    tick(); bubble(); tick(); tick();
    issue(32'h00202623, 32'h414, 32'h0, 32'h11111111);
    tick(); bubble(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid.we", {31'd0, MEM_WB_RD_WE}, 32'd0);
    chk("rst_mid.ir", MEM_WB_IR, 32'd0);
    issue(32'h00C02183, 32'h418, 32'h0, 32'h0);
    tick(); bubble(); tick(); tick();
    chk("rst_mid.lmd", MEM_WB_LMD, 32'h22222222);

    // JAL in EX when reset arrives: redirect must never appear
    issue(32'h008000EF, 32'h020, 32'h0, 32'h0);
    tick();
    bubble();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_jal.taken",  {31'd0, BR_TAKEN}, 32'd0);
    chk("rst_jal.target", BR_TARGET, 32'd0);

`ifdef RV32_MEM_SUBWORD_EN
    // SB x2,9(x0) with 0xAB, then LBU, LB, LW from the same word
    issue(32'h002004A3, 32'h500, 32'h0, 32'h000000AB);
    tick();
    issue(32'h00904183, 32'h504, 32'h0, 32'h0);
    tick();
    issue(32'h00900183, 32'h508, 32'h0, 32'h0);
    tick();
    issue(32'h00802183, 32'h50C, 32'h0, 32'h0);
    tick();
    chk("lbu.lmd", MEM_WB_LMD, 32'h000000AB);
    bubble();
    tick();
    chk("lb.lmd", MEM_WB_LMD, 32'hFFFFFFAB);
    tick();
    chk("sb_lw.lmd", MEM_WB_LMD, 32'hDEADABEF);
`else
    // LW x3,10(x0): low address bits are ignored
    issue(32'h00A02183, 32'h500, 32'h0, 32'h0);
    tick(); bubble(); tick(); tick();
    chk("lw_unaligned.lmd", MEM_WB_LMD, 32'hDEADBEEF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
